// File: rtl/usb_pd_pkg.sv
// Shared types and constants for the USB-PD character arbiter.
// Holds the arbiter FSM state encoding, the character width, the
// end-of-packet marker and the per-channel tag characters.
package usb_pd_pkg;

  localparam int unsigned CHAR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAG  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [CHAR_W-1:0] ASCII_EOP = 8'h0D;
  localparam logic [CHAR_W-1:0] TAG_CH0   = 8'h61;
  localparam logic [CHAR_W-1:0] TAG_CH1   = 8'h62;

endpackage

// File: rtl/usb_pd_char_fifo.sv
// First-word-fall-through character FIFO, one per decoder channel.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write strobe and character; ignored when full unless popping
//   pop        : remove the head; ignored when empty
//   dout       : current head character (valid while !empty)
//   empty/full : occupancy flags
module usb_pd_char_fifo
  import usb_pd_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [CHAR_W-1:0] din,
  input  logic              pop,
  output logic [CHAR_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CHAR_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  // Extra MSB on the pointers separates full from empty.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign dout = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/usb_pd_char_arbiter.sv
// Merges the character streams of two USB-PD decoder channels (CC1/CC2)
// onto one UART. Each channel is buffered in its own FIFO; a granted
// channel is announced by a tag character ('a' or 'b') and then forwarded
// until an EOP character or until it stays empty for IDLE_CYCLES cycles.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   ch0_char/ch0_ready    : channel 0 character and valid strobe
//   ch1_char/ch1_ready    : channel 1 character and valid strobe
//   tx_data/tx_valid      : character stream to the UART
//   tx_ready              : UART accepts tx_data
//   ovf_clear             : clears the sticky overflow flags
//   ovf                   : sticky per-channel overflow flags
//   grant                 : one-hot owning channel, 00 when idle
module usb_pd_char_arbiter
  import usb_pd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned IDLE_CYCLES = 2700
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CHAR_W-1:0] ch0_char,
  input  logic              ch0_ready,
  input  logic [CHAR_W-1:0] ch1_char,
  input  logic              ch1_ready,
  output logic [CHAR_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              ovf_clear,
  output logic [1:0]        ovf,
  output logic [1:0]        grant
);

  localparam int unsigned       CW       = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0]     IDLE_MAX = CW'(IDLE_CYCLES);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_ch;
  logic              w_ch_nxt;
  logic              r_last;
  logic              w_last_nxt;
  logic [CW-1:0]     r_idle_cnt;
  logic [CW-1:0]     w_idle_cnt_nxt;
  logic [1:0]        r_grant;
  logic [1:0]        w_grant_nxt;
  logic [1:0]        r_ovf;

  logic [1:0]        w_push;
  logic [1:0]        w_pop;
  logic [1:0]        w_empty;
  logic [1:0]        w_full;
  logic [1:0]        w_ovf_evt;
  logic [CHAR_W-1:0] w_dout [2];
  logic [CHAR_W-1:0] w_head;
  logic              w_gnt_empty;

  assign w_push = {ch1_ready, ch0_ready};

  usb_pd_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_ch0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push[0]),
    .din   (ch0_char),
    .pop   (w_pop[0]),
    .dout  (w_dout[0]),
    .empty (w_empty[0]),
    .full  (w_full[0])
  );

  usb_pd_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_ch1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push[1]),
    .din   (ch1_char),
    .pop   (w_pop[1]),
    .dout  (w_dout[1]),
    .empty (w_empty[1]),
    .full  (w_full[1])
  );

  assign w_head      = w_dout[r_ch];
  assign w_gnt_empty = w_empty[r_ch];

  // A strobe into a full FIFO is lost unless that FIFO pops in the same cycle.
  assign w_ovf_evt = w_push & w_full & ~w_pop;

  assign grant = r_grant;
  assign ovf   = r_ovf;

  // State and arbitration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ch       <= 1'b0;
      r_last     <= 1'b1;
      r_idle_cnt <= '0;
      r_grant    <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_ch       <= w_ch_nxt;
      r_last     <= w_last_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_grant    <= w_grant_nxt;
    end
  end

  // Sticky overflow; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= 2'b00;
    else        r_ovf <= w_ovf_evt | (r_ovf & ~{2{ovf_clear}});
  end

  // Next-state, pop and UART output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_ch_nxt       = r_ch;
    w_last_nxt     = r_last;
    w_idle_cnt_nxt = '0;
    w_pop          = 2'b00;
    tx_valid       = 1'b0;
    tx_data        = '0;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty[0] && !w_empty[1]) begin
          w_ch_nxt    = ~r_last;
          w_state_nxt = ST_TAG;
        end else if (!w_empty[0]) begin
          w_ch_nxt    = 1'b0;
          w_state_nxt = ST_TAG;
        end else if (!w_empty[1]) begin
          w_ch_nxt    = 1'b1;
          w_state_nxt = ST_TAG;
        end
      end

      ST_TAG: begin
        tx_valid = 1'b1;
        tx_data  = r_ch ? TAG_CH1 : TAG_CH0;
        if (tx_ready) w_state_nxt = ST_DATA;
      end

      ST_DATA: begin
        tx_valid = !w_gnt_empty;
        if (!w_gnt_empty) tx_data = w_head;
        if (w_gnt_empty) begin
          // Saturating idle count; the grant is released on the cycle it reaches the limit.
          w_idle_cnt_nxt = (r_idle_cnt == IDLE_MAX) ? r_idle_cnt : r_idle_cnt + CW'(1);
          if (w_idle_cnt_nxt == IDLE_MAX) begin
            w_last_nxt  = r_ch;
            w_state_nxt = ST_IDLE;
          end
        end else if (tx_ready) begin
          w_pop[r_ch] = 1'b1;
          if (w_head == ASCII_EOP) begin
            w_last_nxt  = r_ch;
            w_state_nxt = ST_IDLE;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    w_grant_nxt = (w_state_nxt == ST_IDLE) ? 2'b00 : (w_ch_nxt ? 2'b10 : 2'b01);
  end

endmodule
